// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: state encodings, opcodes, immediate formats and ALU op classes
package multicycle_control_pkg;
  typedef enum logic [2:0] {
    BUSCA   = 3'd0,
    DECOD   = 3'd1,
    EXEC    = 3'd2,
    MEM     = 3'd3,
    ESCRITA = 3'd4,
    ERRO    = 3'd5
  } estado_t;
  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_ADDI = 6'd1;
  localparam logic [5:0] OP_LW   = 6'd2;
  localparam logic [5:0] OP_SW   = 6'd3;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_J    = 6'd5;
  localparam logic [1:0] FMT_I20 = 2'b00;
  localparam logic [1:0] FMT_I14 = 2'b01;
  localparam logic [1:0] FMT_I15 = 2'b10;
  localparam logic [1:0] FMT_R   = 2'b11;
  localparam logic [1:0] ULA_ADD  = 2'b00;
  localparam logic [1:0] ULA_SUB  = 2'b01;
  localparam logic [1:0] ULA_FUNC = 2'b10;
endpackage

// File: rtl/multicycle_control_decod_formato.sv
// decod_formato: opcode to immediate format, ALU op class and legality
module decod_formato
  import multicycle_control_pkg::*;
(
  input  logic [5:0] opcode,
  output logic [1:0] selecao,
  output logic [1:0] ula_op,
  output logic       legal
);
  always_comb begin
    selecao = (opcode == OP_R) ? FMT_R :
              (opcode == OP_ADDI || opcode == OP_BEQ) ? FMT_I15 :
              (opcode == OP_LW || opcode == OP_SW) ? FMT_I14 : FMT_I20;
    ula_op  = (opcode == OP_R) ? ULA_FUNC : (opcode == OP_BEQ) ? ULA_SUB : ULA_ADD;
    legal   = opcode <= OP_J;
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle CPU control FSM; define MEM_TIMEOUT_EN to fault on stalled memory
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       habilita,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_pronto,
  output logic       mem_req,
  output logic       mem_we,
  output logic [1:0] selecao,
  output logic       ir_escrita,
  output logic       pc_escrita,
  output logic       reg_escrita,
  output logic [1:0] ula_op,
  output logic       concluida,
  output logic       erro,
  output logic [2:0] estado
);
  estado_t    state_q, state_d;
  logic [5:0] op_q, op_d;
  logic [1:0] sel_q, sel_d;
  logic       erro_q, erro_d;
  logic [1:0] dec_sel, dec_ula;
  logic       dec_legal;

  decod_formato u_decod (
    .opcode (op_q),
    .selecao(dec_sel),
    .ula_op (dec_ula),
    .legal  (dec_legal)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CICLOS + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CICLOS;
`endif

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    sel_d       = sel_q;
    erro_d      = erro_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    ir_escrita  = 1'b0;
    pc_escrita  = 1'b0;
    reg_escrita = 1'b0;
    concluida   = 1'b0;
    ula_op      = ULA_ADD;
    case (state_q)
      BUSCA: begin
        mem_req = habilita;
        if (habilita && mem_pronto) begin
          ir_escrita = 1'b1;
          pc_escrita = 1'b1;
          op_d       = opcode;
          state_d    = DECOD;
        end
      end
      DECOD: begin
        sel_d = dec_sel;
        if (op_q == OP_J) begin
          pc_escrita = 1'b1;
          concluida  = 1'b1;
          state_d    = BUSCA;
        end else if (!dec_legal) begin
          erro_d  = 1'b1;
          state_d = ERRO;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        ula_op     = dec_ula;
        pc_escrita = (op_q == OP_BEQ) && zero;
        concluida  = op_q == OP_BEQ;
        state_d    = (op_q == OP_R || op_q == OP_ADDI) ? ESCRITA :
                     (op_q == OP_LW || op_q == OP_SW) ? MEM : BUSCA;
      end
      MEM: begin
        mem_req = 1'b1;
        mem_we  = op_q == OP_SW;
        if (mem_pronto) begin
          concluida = op_q == OP_SW;
          state_d   = (op_q == OP_LW) ? ESCRITA : BUSCA;
        end
      end
      ESCRITA: begin
        reg_escrita = 1'b1;
        concluida   = 1'b1;
        state_d     = BUSCA;
      end
      default: ;
    endcase
`ifdef MEM_TIMEOUT_EN
    // Only BUSCA/MEM raise mem_req and they leave only on mem_pronto, so this also clears on exit
    cnt_d = (mem_req && !mem_pronto) ? cnt_q + 1'b1 : '0;
    if (mem_req && !mem_pronto && cnt_q == CW'(TIMEOUT_CICLOS - 1)) begin
      cnt_d   = '0;
      erro_d  = 1'b1;
      state_d = ERRO;
    end
`endif
    // Reset must silence the Mealy outputs immediately, not just at the next edge
    if (!reset_n) {mem_req, mem_we, ir_escrita, pc_escrita, reg_escrita, concluida, ula_op} = '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BUSCA;
      op_q    <= '0;
      sel_q   <= FMT_I20;
      erro_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sel_q   <= sel_d;
      erro_q  <= erro_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign selecao = sel_q;
  assign erro    = erro_q;
  assign estado  = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed scenarios plus randomized run against an instruction-path model
module tb_multicycle_control;
  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       habilita = 1'b0;
  logic [5:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_pronto = 1'b0;
  logic       mem_req, mem_we, ir_escrita, pc_escrita, reg_escrita, concluida, erro;
  logic [1:0] selecao, ula_op;
  logic [2:0] estado;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  multicycle_control #(.TIMEOUT_CICLOS(16)) dut (
    .clock(clock), .reset_n(reset_n), .habilita(habilita), .opcode(opcode), .zero(zero),
    .mem_pronto(mem_pronto), .mem_req(mem_req), .mem_we(mem_we), .selecao(selecao),
    .ir_escrita(ir_escrita), .pc_escrita(pc_escrita), .reg_escrita(reg_escrita),
    .ula_op(ula_op), .concluida(concluida), .erro(erro), .estado(estado)
  );

  logic [13:0] act;
  assign act = {estado, selecao, ula_op, erro, mem_req, mem_we, ir_escrita, pc_escrita,
                reg_escrita, concluida};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h at %0t", name, got, req, $time);
    end
  endtask

  // Model: an instruction is a fixed list of states after DECOD; BUSCA and MEM wait for mem_pronto
  int         m_cur = 0;
  int         m_nxt;
  int         m_rest[$];
  logic [5:0] m_op = '0;
  logic [1:0] m_sel = '0;
  logic       m_err = 1'b0;
`ifdef MEM_TIMEOUT_EN
  int m_wait = 0;
  bit m_waiting;
`endif

  function automatic logic [1:0] fmt(input logic [5:0] o);
    return o == 0 ? 2'd3 : (o == 1 || o == 4) ? 2'd2 : (o == 2 || o == 3) ? 2'd1 : 2'd0;
  endfunction

  task automatic set_path(input logic [5:0] o);
    case (o)
      6'd0, 6'd1: m_rest = '{2, 4};
      6'd2:       m_rest = '{2, 3, 4};
      6'd3:       m_rest = '{2, 3};
      6'd4:       m_rest = '{2};
      6'd5:       m_rest.delete();
      default:    m_rest = '{5};
    endcase
  endtask

  function automatic logic [13:0] exp_out();
    logic fetch, mem, j, beq, sw;
    logic [1:0] ula;
    if (!reset_n) return '0;
    fetch = m_cur == 0 && habilita;
    mem   = m_cur == 3;
    j     = m_op == 6'd5;
    beq   = m_op == 6'd4;
    sw    = m_op == 6'd3;
    ula   = m_cur != 2 ? 2'd0 : m_op == 6'd0 ? 2'd2 : beq ? 2'd1 : 2'd0;
    return {3'(m_cur), m_sel, ula, m_err, fetch || mem, mem && sw, fetch && mem_pronto,
            (fetch && mem_pronto) || (m_cur == 1 && j) || (m_cur == 2 && beq && zero),
            m_cur == 4,
            m_cur == 4 || (m_cur == 1 && j) || (m_cur == 2 && beq) || (mem && mem_pronto && sw)};
  endfunction

  initial forever begin
    @(posedge clock or negedge reset_n);
    if (!reset_n) begin
      m_cur = 0;
      m_rest.delete();
      m_op  = '0;
      m_sel = '0;
      m_err = 1'b0;
`ifdef MEM_TIMEOUT_EN
      m_wait = 0;
`endif
    end else begin
      m_nxt = m_cur;
`ifdef MEM_TIMEOUT_EN
      m_waiting = ((m_cur == 0 && habilita) || m_cur == 3) && !mem_pronto;
`endif
      if (m_cur == 0 && habilita && mem_pronto) begin
        m_op = opcode;
        set_path(opcode);
        m_nxt = 1;
      end else if (m_cur == 1 || m_cur == 2 || m_cur == 4 || (m_cur == 3 && mem_pronto)) begin
        if (m_cur == 1) m_sel = fmt(m_op);
        m_nxt = 0;
        if (m_rest.size() > 0) m_nxt = m_rest.pop_front();
        if (m_nxt == 5) m_err = 1'b1;
      end
`ifdef MEM_TIMEOUT_EN
      if (m_waiting && m_wait == 15) begin
        m_nxt = 5;
        m_err = 1'b1;
      end
      m_wait = (m_waiting && m_nxt != 5) ? m_wait + 1 : 0;
`endif
      m_cur = m_nxt;
    end
  end

  initial forever begin
    @(negedge clock);
    check("cycle_outputs", 32'(act), 32'(exp_out()));
  end

  task automatic drive(input logic h, input logic [5:0] o, input logic z, input logic p);
    @(posedge clock);
    #1;
    habilita = h; opcode = o; zero = z; mem_pronto = p;
    @(negedge clock);
  endtask

  task automatic pulse_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b0; habilita = 1'b1; mem_pronto = 1'b0;
    @(negedge clock);
    check("rst_estado", estado, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_erro", erro, 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1; habilita = 1'b0;
  endtask

  int errc = 0;

  initial begin
    #2 reset_n = 1'b0;
    habilita = 1'b1;
    @(negedge clock);
    check("reset_mem_req", mem_req, 0);
    check("reset_selecao", selecao, 0);
    @(posedge clock);
    #1 reset_n = 1'b1; habilita = 1'b0;
    // LW, memory answering one cycle after each request
    drive(1, 6'd2, 0, 0); check("lw_busca", estado, 0); check("lw_req", mem_req, 1);
    drive(1, 6'd2, 0, 1); check("lw_ir", ir_escrita, 1); check("lw_pc", pc_escrita, 1);
    drive(0, 6'd0, 0, 0); check("lw_decod", estado, 1);
    drive(0, 6'd0, 0, 0); check("lw_exec", estado, 2); check("lw_sel", selecao, 2'b01);
    drive(0, 6'd0, 0, 0); check("lw_mem", estado, 3); check("lw_we", mem_we, 0);
    drive(0, 6'd0, 0, 1); check("lw_mem2", estado, 3);
    drive(0, 6'd0, 0, 0); check("lw_escrita", estado, 4); check("lw_reg", reg_escrita, 1);
    check("lw_concl", concluida, 1);
    drive(0, 6'd0, 0, 0); check("lw_back", estado, 0); check("lw_reg_off", reg_escrita, 0);
    // BEQ taken then not taken
    drive(1, 6'd4, 0, 1); check("beq1_ir", ir_escrita, 1);
    drive(0, 6'd0, 1, 0); check("beq1_decod", estado, 1);
    drive(0, 6'd0, 1, 0); check("beq1_pc", pc_escrita, 1); check("beq1_concl", concluida, 1);
    check("beq1_sel", selecao, 2'b10); check("beq1_ula", ula_op, 2'b01);
    drive(1, 6'd4, 0, 1); check("beq2_busca", estado, 0);
    drive(0, 6'd0, 0, 0);
    drive(0, 6'd0, 0, 0); check("beq2_pc", pc_escrita, 0); check("beq2_concl", concluida, 1);
    // J
    drive(1, 6'd5, 0, 1); check("j_pc0", pc_escrita, 1);
    drive(0, 6'd0, 0, 0); check("j_pc1", pc_escrita, 1); check("j_concl", concluida, 1);
    drive(0, 6'd0, 0, 0); check("j_back", estado, 0); check("j_sel", selecao, 2'b00);
    // Illegal opcode, then ERRO must absorb everything
    drive(1, 6'h3f, 0, 1);
    drive(1, 6'd0, 0, 0); check("ill_decod", estado, 1);
    drive(1, 6'd0, 0, 0); check("ill_erro_state", estado, 5); check("ill_erro", erro, 1);
    for (int i = 0; i < 20; i++) begin
      drive(1, 6'($urandom), 1'($urandom), 1'($urandom));
      check("erro_mem_req", mem_req, 0);
      check("erro_stuck", estado, 5);
    end
    pulse_reset();
    drive(0, 6'd0, 0, 0); check("post_rst_erro", erro, 0); check("post_rst_estado", estado, 0);
    // SW with memory withheld
    drive(1, 6'd3, 0, 1);
    drive(0, 6'd0, 0, 0);
    drive(0, 6'd0, 0, 0);
    for (int i = 0; i < 20; i++) drive(0, 6'd0, 0, 0);
`ifdef MEM_TIMEOUT_EN
    check("sw_timeout_state", estado, 5); check("sw_timeout_erro", erro, 1);
`else
    check("sw_wait_state", estado, 3); check("sw_wait_we", mem_we, 1);
`endif
    pulse_reset();
    // Reset in the middle of an LW memory access
    drive(1, 6'd2, 0, 1);
    drive(0, 6'd0, 0, 0);
    drive(0, 6'd0, 0, 0);
    drive(0, 6'd0, 0, 0); check("mid_mem_req", mem_req, 1);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_req", mem_req, 0); check("mid_rst_estado", estado, 0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    drive(1, 6'd2, 0, 1);
    drive(0, 6'd0, 0, 0);
    drive(0, 6'd0, 0, 0);
    drive(0, 6'd0, 0, 1); check("refetch_mem", estado, 3);
    drive(0, 6'd0, 0, 0); check("refetch_concl", concluida, 1);
    // Randomized traffic, including spurious mem_pronto and occasional resets
    for (int i = 0; i < 3000; i++) begin
      @(posedge clock);
      #1;
      if (!reset_n) reset_n = 1'b1;
      else if ((m_cur == 5 && ++errc > 4) || $urandom_range(399) == 0) begin
        reset_n = 1'b0;
        errc = 0;
      end
      habilita = $urandom_range(3) != 0;
      opcode   = ($urandom_range(29) == 0) ? 6'($urandom) : 6'($urandom_range(5));
      zero     = 1'($urandom);
      #1;
      mem_pronto = mem_req ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
    end
    @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter TIMEOUT_CICLOS, default 16, max memory wait cycles before error (used only with MEM_TIMEOUT_EN).
REQ-002 SHALL have ports: clock in 1, single clock, all state on rising edge; reset_n in 1, asynchronous active-low reset.
REQ-003 SHALL have ports: habilita in 1, start fetch when high; opcode in 6, instruction bits [31:26] from instruction bus, valid with mem_pronto in BUSCA; zero in 1, ALU zero flag.
REQ-004 SHALL have ports: mem_req out 1, memory request; mem_we out 1, memory write; mem_pronto in 1, memory done (1-cycle pulse).
REQ-005 SHALL have ports: selecao out 2, sign-extender format select; ir_escrita, pc_escrita, reg_escrita out 1 each, write strobes; ula_op out 2, ALU op class.
REQ-006 SHALL have ports: concluida out 1, instruction-retired pulse; erro out 1, sticky fault flag; estado out 3, current state for debug.

Function
REQ-007 SHALL implement states BUSCA=0, DECOD=1, EXEC=2, MEM=3, ESCRITA=4, ERRO=5; estado = current state.
REQ-008 In BUSCA, habilita=0 SHALL hold BUSCA with mem_req=0; habilita=1 SHALL assert mem_req until mem_pronto.
REQ-009 On mem_pronto in BUSCA SHALL, same cycle, pulse ir_escrita and pc_escrita (PC+4), latch opcode, and go to DECOD.
REQ-010 DECOD SHALL drive selecao from latched opcode, registered and held until next DECOD: R 000000 -> 11; ADDI 000001 and BEQ 000100 -> 10 (15-bit); LW 000010 and SW 000011 -> 01 (14-bit); J 000101 -> 00 (20-bit).
REQ-011 DECOD SHALL go: J -> pc_escrita pulse, concluida pulse, BUSCA; any other undefined opcode -> ERRO with erro=1; else EXEC.
REQ-012 EXEC SHALL drive ula_op: R=10, ADDI/LW/SW=00, BEQ=01; otherwise ula_op=00.
REQ-013 EXEC SHALL go: R/ADDI -> ESCRITA; LW/SW -> MEM; BEQ -> BUSCA with pc_escrita=zero and concluida pulse.
REQ-014 MEM SHALL assert mem_req, and mem_we for SW only, until mem_pronto; then LW -> ESCRITA, SW -> BUSCA with concluida pulse.
REQ-015 ESCRITA SHALL pulse reg_escrita and concluida for one cycle, then go to BUSCA.
REQ-016 Strobes (ir_escrita, pc_escrita, reg_escrita, concluida) SHALL be one-cycle combinational Moore/Mealy decodes; never asserted in ERRO.
REQ-017 ERRO SHALL be absorbing with all strobes, mem_req and mem_we at 0; only reset_n exits.
REQ-018 mem_pronto outside BUSCA/MEM SHALL be ignored; habilita SHALL be sampled only in BUSCA.
REQ-019 Cycles per instruction with zero-wait memory: J 2, BEQ 3, R/ADDI/SW 4, LW 5.

Reset
REQ-020 reset_n=0 SHALL immediately force BUSCA, selecao=00, latched opcode=0, erro=0, timeout counter=0, and all strobes/mem outputs 0.
REQ-021 Reset mid-MEM SHALL drop mem_req/mem_we asynchronously; the pending access is abandoned.

Configuration
REQ-022 With MEM_TIMEOUT_EN defined, a counter SHALL count cycles with mem_req=1 and mem_pronto=0, clearing on mem_pronto or state exit.
REQ-023 With MEM_TIMEOUT_EN, count reaching TIMEOUT_CICLOS SHALL go to ERRO and set erro.
REQ-024 Without MEM_TIMEOUT_EN SHALL wait indefinitely; no counter logic exists; erro set only by illegal opcode.

Structure
REQ-025 A shared package SHALL hold state encodings, opcode constants, selecao format codes (FMT_I20=00, FMT_I14=01, FMT_I15=10, FMT_R=11) and ula_op codes.
REQ-026 Opcode-to-format/ula_op decode SHALL be sub-module decod_formato (combinational, opcode in, selecao/ula_op/legal out).

Verification
REQ-027 LW (000010), mem_pronto 1 cycle after each request -> states 0,1,2,3,4,0; selecao=01; one reg_escrita; one concluida.
REQ-028 BEQ (000100) with zero=1, then zero=0 -> selecao=10; pc_escrita in EXEC only for first; concluida each.
REQ-029 Opcode 111111 -> ERRO, erro=1, mem_req stays 0 for 20 cycles with habilita=1; reset_n pulse -> BUSCA, erro=0.
REQ-030 SW with mem_pronto withheld 20 cycles -> with MEM_TIMEOUT_EN: ERRO after 16 wait cycles; without: still MEM with mem_we=1.
REQ-031 reset_n low mid-MEM (LW) -> mem_req=0 same cycle, estado=0; after release, next fetch completes normally.
REQ-032 J (000101) -> selecao=00, two pc_escrita pulses (BUSCA, DECOD), back in BUSCA at cycle 2.
